// File: rtl/ipml_rom_v1_6_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel waveform ROM player.
package ipml_rom_v1_6_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel index width, kept at least one bit so a single-channel build still has a port.
  function automatic int ch_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  // ROM latency is 1 + output_reg; one extra slot covers the sample being presented.
  function automatic int fifo_depth(input int output_reg);
    return output_reg + 2;
  endfunction

endpackage

// File: rtl/ipml_rom_v1_6_out_fifo.sv
// Small register FIFO holding {sample, channel, last} between the ROM and the output stream.
module ipml_rom_v1_6_out_fifo
  import ipml_rom_v1_6_pkg::*;
#(
  parameter int c_DEPTH = 3,
  parameter int c_WIDTH = 8,
  localparam int CNT_W = clog2(c_DEPTH + 1),
  localparam int PTR_W = ch_width(c_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [c_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic [c_WIDTH-1:0] head,
  output logic               valid,
  output logic [CNT_W-1:0]   count
);

  logic [c_WIDTH-1:0] mem [c_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(c_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define validity and the head is masked downstream.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/ipml_rom_v1_6_rom.sv
// Single-port ROM in read-only mode; the table is an address ramp (word i holds value i).
module ipml_rom_v1_6_rom #(
  parameter int c_ADDR_WIDTH = 10,
  parameter int c_DATA_WIDTH = 8,
  parameter int c_OUTPUT_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    addr_strobe,
  input  logic                    rd_oce,
  input  logic [c_ADDR_WIDTH-1:0] addr,
  output logic [c_DATA_WIDTH-1:0] rd_data
);

  logic [c_ADDR_WIDTH-1:0] addr_q;

  function automatic logic [c_DATA_WIDTH-1:0] rom_word(input logic [c_ADDR_WIDTH-1:0] a);
    return c_DATA_WIDTH'(a);
  endfunction

  // addr_strobe high holds the previously latched address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (clk_en && !addr_strobe) begin
      addr_q <= addr;
    end
  end

  generate
    if (c_OUTPUT_REG != 0) begin : g_oreg
      logic [c_DATA_WIDTH-1:0] data_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q <= '0;
        end else if (clk_en && rd_oce) begin
          data_q <= rom_word(addr_q);
        end
      end
      assign rd_data = data_q;
    end else begin : g_noreg
      assign rd_data = rd_oce ? rom_word(addr_q) : '0;
    end
  endgenerate

endmodule

// File: rtl/ipml_rom_v1_6_wave_player.sv
// Multi-channel DDS waveform player: round-robin ROM reads, credit-controlled output FIFO, valid/ready stream.
module ipml_rom_v1_6_wave_player
  import ipml_rom_v1_6_pkg::*;
#(
  parameter int c_ADDR_WIDTH  = 10,
  parameter int c_DATA_WIDTH  = 8,
  parameter int c_CH_NUM      = 2,
  parameter int c_PHASE_WIDTH = 32,
  parameter int c_OUTPUT_REG  = 1,
  localparam int CH_W = ch_width(c_CH_NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     cfg_wr,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [c_PHASE_WIDTH-1:0] cfg_inc,
  input  logic [c_PHASE_WIDTH-1:0] cfg_phase,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [c_DATA_WIDTH-1:0]  out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  output logic                     busy
);

  localparam int LAT   = 1 + c_OUTPUT_REG;
  localparam int DEPTH = fifo_depth(c_OUTPUT_REG);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam int FW    = c_DATA_WIDTH + CH_W + 1;

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
    logic            last;
  } tag_t;

  state_t                   state, state_nxt;
  logic [c_PHASE_WIDTH-1:0] acc [c_CH_NUM];
  logic [c_PHASE_WIDTH-1:0] inc [c_CH_NUM];
  logic [CH_W-1:0]          rr_ch;
  logic                     rr_last;
  tag_t                     tag_q [LAT];
  logic [CNT_W-1:0]         fifo_count, inflight;
  logic                     fifo_valid, issue, pop;
  logic [c_ADDR_WIDTH-1:0]  rom_addr;
  logic [c_DATA_WIDTH-1:0]  rom_data;
  logic [FW-1:0]            fifo_head;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start && !stop) state_nxt = ST_RUN;
      ST_RUN:   if (stop) state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight == '0 && fifo_count == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CNT_W'(tag_q[i].vld);
  end

  // A sample accepted this cycle frees its FIFO slot at the same edge, which keeps 1 sample/clk.
  assign pop      = fifo_valid && out_ready;
  assign issue    = (state == ST_RUN) &&
                    ((int'(fifo_count) + int'(inflight)) < (DEPTH + int'(pop)));
  assign rr_last  = (rr_ch == CH_W'(c_CH_NUM - 1));
  assign rom_addr = acc[rr_ch][c_PHASE_WIDTH-1 -: c_ADDR_WIDTH];

  // A config write to the issuing channel overrides that cycle's phase step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_CH_NUM; i++) begin
        acc[i] <= '0;
        inc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_CH_NUM; i++) begin
        if (cfg_wr && cfg_ch == CH_W'(i)) begin
          acc[i] <= cfg_phase;
          inc[i] <= cfg_inc;
        end else if (issue && rr_ch == CH_W'(i)) begin
          acc[i] <= acc[i] + inc[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rr_ch <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_RUN) rr_ch <= '0;
      else if (issue) rr_ch <= rr_last ? '0 : rr_ch + 1'b1;
      tag_q[0] <= '{vld: issue, ch: rr_ch, last: rr_last};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  ipml_rom_v1_6_rom #(
    .c_ADDR_WIDTH (c_ADDR_WIDTH),
    .c_DATA_WIDTH (c_DATA_WIDTH),
    .c_OUTPUT_REG (c_OUTPUT_REG)
  ) u_rom (
    .clk         (clk),
    .rst         (~rst_n),
    .clk_en      (1'b1),
    .addr_strobe (1'b0),
    .rd_oce      (1'b1),
    .addr        (rom_addr),
    .rd_data     (rom_data)
  );

  ipml_rom_v1_6_out_fifo #(
    .c_DEPTH (DEPTH),
    .c_WIDTH (FW)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_q[LAT-1].vld),
    .push_data ({rom_data, tag_q[LAT-1].ch, tag_q[LAT-1].last}),
    .pop       (pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign out_valid                    = fifo_valid;
  assign {out_data, out_ch, out_last} = fifo_valid ? fifo_head : '0;
  assign busy                         = (state != ST_IDLE);

endmodule

// File: tb/tb_ipml_rom_v1_6_wave_player.sv
// Self-checking bench: lazy channel-level DDS model plus directed latency, stall, wrap, config-race and reset checks.
module tb_ipml_rom_v1_6_wave_player;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int CH = 2;
  localparam int PW = 32;
  localparam int L1 = 2;  // main instance, output register on
  localparam int L0 = 1;  // second instance, output register off

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, cfg_wr = 1'b0, out_ready = 1'b1;
  logic [0:0]    cfg_ch = '0;
  logic [PW-1:0] cfg_inc = '0, cfg_phase = '0;
  logic          out_valid, out_last, busy;
  logic [DW-1:0] out_data;
  logic [0:0]    out_ch;

  logic          start0 = 1'b0, stop0 = 1'b0;
  logic          v0, last0, busy0;
  logic [DW-1:0] data0;
  logic [0:0]    ch0;

  always #5 clk = ~clk;

  ipml_rom_v1_6_wave_player #(
    .c_ADDR_WIDTH(AW), .c_DATA_WIDTH(DW), .c_CH_NUM(CH), .c_PHASE_WIDTH(PW), .c_OUTPUT_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last), .busy(busy)
  );

  ipml_rom_v1_6_wave_player #(
    .c_ADDR_WIDTH(AW), .c_DATA_WIDTH(DW), .c_CH_NUM(CH), .c_PHASE_WIDTH(PW), .c_OUTPUT_REG(0)
  ) dut_r0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .out_valid(v0), .out_ready(1'b1),
    .out_data(data0), .out_ch(ch0), .out_last(last0), .busy(busy0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: each channel is a phase value stepped per emitted sample; the table word equals its address.
  logic [PW-1:0] m_acc [CH];
  logic [PW-1:0] m_inc [CH];
  int            m_rr, m_idx;
  bit            pend;
  int            pend_at, pend_ch;
  logic [PW-1:0] pend_acc, pend_inc;

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_acc[i] = '0;
      m_inc[i] = '0;
    end
    m_rr = 0;
    m_idx = 0;
    pend = 1'b0;
  endfunction

  function automatic void model_cfg(input int ch, input logic [PW-1:0] inc_v, input logic [PW-1:0] phase_v);
    m_inc[ch] = inc_v;
    m_acc[ch] = phase_v;
  endfunction

  function automatic void model_start();
    m_rr = 0;
    m_idx = 0;
  endfunction

  task automatic model_next(output int ch, output bit last, output logic [DW-1:0] data);
    if (pend && m_idx == pend_at) begin
      model_cfg(pend_ch, pend_inc, pend_acc);
      pend = 1'b0;
    end
    ch   = m_rr;
    data = DW'(m_acc[ch] / (64'd1 << (PW - AW)));
    last = (ch == CH - 1);
    m_acc[ch] = m_acc[ch] + m_inc[ch];
    m_rr  = (m_rr + 1) % CH;
    m_idx++;
  endtask

  logic [DW-1:0] obs_data[$];
  int            obs_ch[$];
  logic [DW-1:0] obs0[$];
  bit            prev_stall = 1'b0;
  logic [DW+1:0] prev_word;
  int            e_ch;
  bit            e_last;
  logic [DW-1:0] e_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_word", {out_data, out_ch, out_last}, prev_word);
      end
      if (out_valid && out_ready) begin
        model_next(e_ch, e_last, e_data);
        check("stream_data", out_data, e_data);
        check("stream_ch", out_ch, e_ch);
        check("stream_last", out_last, e_last);
        obs_data.push_back(out_data);
        obs_ch.push_back(int'(out_ch));
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_data, out_ch, out_last};
    end
  end

  always @(negedge clk) if (rst_n && v0) obs0.push_back(data0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input logic [PW-1:0] inc_v, input logic [PW-1:0] phase_v);
    cfg_wr = 1'b1; cfg_ch = 1'(ch); cfg_inc = inc_v; cfg_phase = phase_v;
    tick();
    cfg_wr = 1'b0;
    model_cfg(ch, inc_v, phase_v);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit rand_ready);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    check(tag, busy, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int exp_seq[8];
    int lat1, lat0, n;
    logic [DW-1:0] w0[$];
    exp_seq = '{0, 0, 1, 2, 2, 4, 3, 6};
    model_reset();

    // Reset state
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Basic stepping and latency on both ROM latencies
    cfg(0, 32'd1 << 22, 32'd0);
    cfg(1, 32'd1 << 23, 32'd0);
    start0 = 1'b1;
    do_start();
    start0 = 1'b0;
    check("busy_run", busy, 1);
    n = 0; lat1 = -1; lat0 = -1;
    while ((lat1 < 0 || lat0 < 0) && n < 20) begin
      tick();
      n++;
      if (lat1 < 0 && out_valid) lat1 = n;
      if (lat0 < 0 && v0) lat0 = n;
    end
    check("latency_oreg1", lat1, L1 + 1);
    check("latency_oreg0", lat0, L0 + 1);
    repeat (8) tick();
    check("throughput", obs_data.size(), 8);
    stop = 1'b1; stop0 = 1'b1;
    tick();
    stop = 1'b0; stop0 = 1'b0;
    n = 0;
    while (busy0 && n < 100) begin tick(); n++; end
    check("idle_oreg0", busy0, 0);
    wait_idle("idle_basic", 1'b0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("seq_data%0d", i), obs_data[i], exp_seq[i]);
      check($sformatf("seq_ch%0d", i), obs_ch[i], i % 2);
      check($sformatf("seq0_data%0d", i), obs0[i], exp_seq[i]);
    end

    // Start under back-pressure, stop with the FIFO full, then drain
    obs_data.delete(); obs_ch.delete();
    out_ready = 1'b0;
    do_start();
    repeat (20) tick();
    check("stall_valid", out_valid, 1);
    do_stop();
    repeat (5) tick();
    check("drain_busy", busy, 1);
    check("drain_none_taken", obs_data.size(), 0);
    out_ready = 1'b1;
    wait_idle("idle_drain", 1'b0);
    check("drain_count", obs_data.size(), L1 + 1);

    // Resume after stop: stalled start, release, run, stop
    obs_data.delete(); obs_ch.delete();
    out_ready = 1'b0;
    do_start();
    repeat (20) tick();
    out_ready = 1'b1;
    repeat (30) tick();
    do_stop();
    wait_idle("idle_resume", 1'b0);
    check("resume_first_ch", obs_ch[0], 0);

    // Randomised increments, phases and back-pressure
    for (int r = 0; r < 3; r++) begin
      cfg(0, $urandom, $urandom);
      cfg(1, $urandom, $urandom);
      do_start();
      repeat (150) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      do_stop();
      wait_idle($sformatf("idle_rand%0d", r), 1'b1);
    end

    // Phase wrap on channel 0
    obs_data.delete(); obs_ch.delete();
    cfg(0, 32'd1 << 22, 32'hFFC0_0000);
    cfg(1, 32'd1 << 23, 32'd0);
    do_start();
    repeat (14) tick();
    do_stop();
    wait_idle("idle_wrap", 1'b0);
    foreach (obs_data[i]) if (obs_ch[i] == 0) w0.push_back(obs_data[i]);
    check("wrap_count", w0.size() >= 3, 1);
    check("wrap_a0", w0[0], 1023);
    check("wrap_a1", w0[1], 0);
    check("wrap_a2", w0[2], 1);

    // Config write to the channel being issued on that very cycle
    obs_data.delete(); obs_ch.delete();
    cfg(0, 32'd1 << 22, 32'd0);
    cfg(1, 32'd1 << 23, 32'd0);
    pend = 1'b1; pend_at = 3; pend_ch = 0;
    pend_acc = 32'h4000_0000; pend_inc = 32'd1 << 22;
    do_start();
    tick();
    tick();
    cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_inc = 32'd1 << 22; cfg_phase = 32'h4000_0000;
    tick();
    cfg_wr = 1'b0;
    repeat (10) tick();
    do_stop();
    wait_idle("idle_cfgrace", 1'b0);
    check("race_count", obs_data.size() >= 5, 1);
    check("race_old_ch", obs_ch[2], 0);
    check("race_old_addr", obs_data[2], 1);
    check("race_new_ch", obs_ch[4], 0);
    check("race_new_addr", obs_data[4], 256);

    // Asynchronous reset in the middle of a run
    cfg(0, 32'd3 << 22, 32'd0);
    do_start();
    repeat (6) tick();
    check("pre_reset_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_ch", out_ch, 0);
    check("arst_last", out_last, 0);
    check("arst_busy", busy, 0);
    model_reset();
    obs_data.delete(); obs_ch.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_valid", out_valid, 0);
    do_start();
    repeat (10) tick();
    do_stop();
    wait_idle("idle_post_reset", 1'b0);
    check("post_reset_data", obs_data[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
